lsu_mem_master: RTL and testbench

LSU_MEM_MASTER -- requirements
Module: lsu_mem_master

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_mem_master_if.sv | 46 ++++
 rtl/lsu_align.sv | 55 +++++
 rtl/lsu_mem_master.sv | 105 ++++++++++
 tb/tb_lsu_mem_master.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit memory master: access sizes,
// FSM states and the alignment legality check.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_B   = 2'd0,
      SZ_H   = 2'd1,
      SZ_W   = 2'd2,
      SZ_RSV = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

   // A request is illegal for the reserved size or when it is not
   // naturally aligned to its own width.
   function automatic logic is_illegal(input size_e size, input logic [1:0] offs);
      logic bad;
      case (size)
         SZ_B:    bad = 1'b0;
         SZ_H:    bad = offs[0];
         SZ_W:    bad = (offs != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Pipeline request/response handshake plus the memory read/write ports.
// The master modport is the LSU side; slave is the pipeline/memory side.
interface lsu_mem_master_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_wen;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  req_size;
   logic        req_unsigned;

   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_err;

   logic        mem_ren;
   logic [31:0] mem_raddr;
   logic [31:0] mem_rdata;
   logic        mem_wen;
   logic [31:0] mem_waddr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;

   modport master (
      input  req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned,
      output req_ready,
      output resp_valid, resp_rdata, resp_err,
      input  resp_ready,
      output mem_ren, mem_raddr,
      input  mem_rdata,
      output mem_wen, mem_waddr, mem_wdata, mem_wmask
   );

   modport slave (
      output req_valid, req_wen, req_addr, req_wdata, req_size, req_unsigned,
      input  req_ready,
      input  resp_valid, resp_rdata, resp_err,
      output resp_ready,
      input  mem_ren, mem_raddr,
      output mem_rdata,
      input  mem_wen, mem_waddr, mem_wdata, mem_wmask
   );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane alignment: store data replication and byte mask, and load
// data extraction with sign/zero extension. Purely combinational.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [1:0]  offs,
   input  size_e       size,
   input  logic        uns,
   input  logic [31:0] wdata_raw,
   input  logic [31:0] rdata_raw,
   output logic [3:0]  wmask,
   output logic [31:0] wdata,
   output logic [31:0] rdata
);

   logic [31:0] shifted;

   assign shifted = rdata_raw >> {offs, 3'b000};

   // Store lanes: replicate narrow data across the word and select lanes by offset.
   always_comb begin
      wmask = 4'b0000;
      wdata = 32'h0;
      case (size)
         SZ_B: begin
            wmask = 4'b0001 << offs;
            wdata = {4{wdata_raw[7:0]}};
         end
         SZ_H: begin
            wmask = 4'b0011 << offs;
            wdata = {2{wdata_raw[15:0]}};
         end
         SZ_W: begin
            wmask = 4'b1111;
            wdata = wdata_raw;
         end
         default: begin
            wmask = 4'b0000;
            wdata = 32'h0;
         end
      endcase
   end

   // Load lanes: right-align the addressed lane, then extend; word loads ignore uns.
   always_comb begin
      rdata = 32'h0;
      case (size)
         SZ_B:    rdata = uns ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
         SZ_H:    rdata = uns ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
         SZ_W:    rdata = shifted;
         default: rdata = 32'h0;
      endcase
   end

endmodule

// File: rtl/lsu_mem_master.sv
// Single-outstanding load/store master: accepts one pipeline request,
// issues a one-cycle memory strobe, and holds the response until consumed.
module lsu_mem_master
   import lsu_pkg::*;
(
   input  logic             clock,
   input  logic             reset,
   lsu_mem_master_if.master bus
);

   state_e      state;
   state_e      state_next;
   logic        run;
   logic        accept;
   logic        illegal;

   logic        wen_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   size_e       size_q;
   logic        uns_q;

   logic [31:0] rdata_q;
   logic        err_q;

   logic [3:0]  wmask_al;
   logic [31:0] wdata_al;
   logic [31:0] rdata_fmt;
   logic        in_access;

   assign accept    = bus.req_valid && bus.req_ready;
   assign illegal   = is_illegal(size_e'(bus.req_size), bus.req_addr[1:0]);
   assign in_access = (state == ACCESS);

   lsu_align u_align (
      .offs      (addr_q[1:0]),
      .size      (size_q),
      .uns       (uns_q),
      .wdata_raw (wdata_q),
      .rdata_raw (bus.mem_rdata),
      .wmask     (wmask_al),
      .wdata     (wdata_al),
      .rdata     (rdata_fmt)
   );

   // State register; reset forces IDLE immediately, killing any strobe.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // Holds req_ready low through reset and until the first edge after release.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) run <= 1'b0;
      else        run <= 1'b1;
   end

   // Next-state: illegal requests skip the memory access entirely.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = illegal ? RESP : ACCESS;
         ACCESS:  state_next = RESP;
         RESP:    if (bus.resp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Request fields are captured on accept and only used while busy.
   always_ff @(posedge clock) begin
      if (accept) begin
         wen_q   <= bus.req_wen;
         addr_q  <= bus.req_addr;
         wdata_q <= bus.req_wdata;
         size_q  <= size_e'(bus.req_size);
         uns_q   <= bus.req_unsigned;
      end
   end

   // Response register: error decided at accept, load data captured at end of ACCESS.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
      end else if (accept) begin
         rdata_q <= 32'h0;
         err_q   <= illegal;
      end else if (in_access && !wen_q) begin
         rdata_q <= rdata_fmt;
      end
   end

   assign bus.req_ready  = run && (state == IDLE);
   assign bus.resp_valid = (state == RESP);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;

   assign bus.mem_ren   = in_access && !wen_q;
   assign bus.mem_wen   = in_access && wen_q;
   assign bus.mem_raddr = bus.mem_ren ? {addr_q[31:2], 2'b00} : 32'h0;
   assign bus.mem_waddr = bus.mem_wen ? {addr_q[31:2], 2'b00} : 32'h0;
   assign bus.mem_wdata = bus.mem_wen ? wdata_al : 32'h0;
   assign bus.mem_wmask = bus.mem_wen ? wmask_al : 4'b0000;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench for lsu_mem_master: a vector table of single transactions
// plus hand-written reset, backpressure and back-to-back sequences.
module tb_lsu_mem_master;

   logic clock;
   logic reset;

   lsu_mem_master_if bus();

   lsu_mem_master dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      string       name;
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] mrd;
      logic        err;
      logic [31:0] rdata;
      logic [31:0] mwdata;
      logic [3:0]  mask;
   } vec_t;

   vec_t vecs[14];

   int n_cmp;
   int n_fail;
   int strobe_cnt;

   // Count memory strobe cycles mid-cycle, away from the active edge.
   always @(negedge clock) begin
      if (bus.mem_ren || bus.mem_wen) strobe_cnt <= strobe_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive_req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [1:0] size, input logic uns);
      bus.req_valid    = 1'b1;
      bus.req_wen      = wen;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
      bus.req_size     = size;
      bus.req_unsigned = uns;
   endtask

   task automatic run_vec(input vec_t v);
      int base;
      logic [31:0] wa;
      wa = {v.addr[31:2], 2'b00};
      @(negedge clock);
      bus.mem_rdata  = v.mrd;
      bus.resp_ready = 1'b0;
      drive_req(v.wen, v.addr, v.wdata, v.size, v.uns);
      base = strobe_cnt;
      check1({v.name, " ready_idle"}, bus.req_ready, 1'b1);
      @(posedge clock); #1;
      bus.req_valid = 1'b0;
      if (v.err) begin
         check1({v.name, " err_valid"}, bus.resp_valid, 1'b1);
         check1({v.name, " err_flag"}, bus.resp_err, 1'b1);
         check32({v.name, " err_rdata"}, bus.resp_rdata, 32'h0);
         check1({v.name, " err_no_ren"}, bus.mem_ren, 1'b0);
         check1({v.name, " err_no_wen"}, bus.mem_wen, 1'b0);
      end else begin
         check1({v.name, " acc_no_valid"}, bus.resp_valid, 1'b0);
         check1({v.name, " acc_not_ready"}, bus.req_ready, 1'b0);
         check1({v.name, " acc_ren"}, bus.mem_ren, !v.wen);
         check1({v.name, " acc_wen"}, bus.mem_wen, v.wen);
         check32({v.name, " acc_raddr"}, bus.mem_raddr, v.wen ? 32'h0 : wa);
         check32({v.name, " acc_waddr"}, bus.mem_waddr, v.wen ? wa : 32'h0);
         check32({v.name, " acc_wdata"}, bus.mem_wdata, v.wen ? v.mwdata : 32'h0);
         check32({v.name, " acc_wmask"}, {28'h0, bus.mem_wmask}, v.wen ? {28'h0, v.mask} : 32'h0);
         @(posedge clock); #1;
         check1({v.name, " resp_valid"}, bus.resp_valid, 1'b1);
         check1({v.name, " resp_err"}, bus.resp_err, 1'b0);
         check32({v.name, " resp_rdata"}, bus.resp_rdata, v.rdata);
         check1({v.name, " resp_no_ren"}, bus.mem_ren, 1'b0);
      end
      bus.resp_ready = 1'b1;
      @(posedge clock); #1;
      bus.resp_ready = 1'b0;
      check1({v.name, " done_valid"}, bus.resp_valid, 1'b0);
      check1({v.name, " done_ready"}, bus.req_ready, 1'b1);
      check_int({v.name, " strobes"}, strobe_cnt - base, v.err ? 0 : 1);
   endtask

   initial begin
      int base;
      int n_acc;
      int acc_k[3];
      logic [31:0] held;

      n_cmp      = 0;
      n_fail     = 0;
      strobe_cnt = 0;

      //          name        wen   addr          wdata         sz    uns   mem_rdata     err   rdata         mwdata        mask
      vecs[0]  = '{"st_b3",   1'b1, 32'h80000003, 32'h000000AB, 2'd0, 1'b0, 32'h0,        1'b0, 32'h0,        32'hABABABAB, 4'b1000};
      vecs[1]  = '{"ld_h_s",  1'b0, 32'h80000002, 32'h0,        2'd1, 1'b0, 32'h80011234, 1'b0, 32'hFFFF8001, 32'h0,        4'b0000};
      vecs[2]  = '{"ld_h_u",  1'b0, 32'h80000002, 32'h0,        2'd1, 1'b1, 32'h80011234, 1'b0, 32'h00008001, 32'h0,        4'b0000};
      vecs[3]  = '{"ld_w_mis",1'b0, 32'h80000001, 32'h0,        2'd2, 1'b0, 32'h12345678, 1'b1, 32'h0,        32'h0,        4'b0000};
      vecs[4]  = '{"st_h2",   1'b1, 32'h00000012, 32'h1234CDEF, 2'd1, 1'b0, 32'h0,        1'b0, 32'h0,        32'hCDEFCDEF, 4'b1100};
      vecs[5]  = '{"st_w",    1'b1, 32'h00000020, 32'hDEADBEEF, 2'd2, 1'b0, 32'h0,        1'b0, 32'h0,        32'hDEADBEEF, 4'b1111};
      vecs[6]  = '{"ld_b1_s", 1'b0, 32'h00000041, 32'h0,        2'd0, 1'b0, 32'h0000F600, 1'b0, 32'hFFFFFFF6, 32'h0,        4'b0000};
      vecs[7]  = '{"ld_b3_u", 1'b0, 32'h00000043, 32'h0,        2'd0, 1'b1, 32'h9A000000, 1'b0, 32'h0000009A, 32'h0,        4'b0000};
      vecs[8]  = '{"ld_w_s",  1'b0, 32'h00000100, 32'h0,        2'd2, 1'b0, 32'h87654321, 1'b0, 32'h87654321, 32'h0,        4'b0000};
      vecs[9]  = '{"ld_w_u",  1'b0, 32'h00000100, 32'h0,        2'd2, 1'b1, 32'h87654321, 1'b0, 32'h87654321, 32'h0,        4'b0000};
      vecs[10] = '{"ld_rsv",  1'b0, 32'h00000000, 32'h0,        2'd3, 1'b0, 32'hFFFFFFFF, 1'b1, 32'h0,        32'h0,        4'b0000};
      vecs[11] = '{"st_h_mis",1'b1, 32'h00000003, 32'h00001234, 2'd1, 1'b0, 32'h0,        1'b1, 32'h0,        32'h0,        4'b0000};
      vecs[12] = '{"ld_h0_s", 1'b0, 32'h00000000, 32'h0,        2'd1, 1'b0, 32'h00007FFF, 1'b0, 32'h00007FFF, 32'h0,        4'b0000};
      vecs[13] = '{"ld_b0_s", 1'b0, 32'h00000004, 32'h0,        2'd0, 1'b0, 32'h000000FF, 1'b0, 32'hFFFFFFFF, 32'h0,        4'b0000};

      reset            = 1'b0;
      bus.req_valid    = 1'b0;
      bus.req_wen      = 1'b0;
      bus.req_addr     = 32'h0;
      bus.req_wdata    = 32'h0;
      bus.req_size     = 2'd0;
      bus.req_unsigned = 1'b0;
      bus.resp_ready   = 1'b0;
      bus.mem_rdata    = 32'h0;

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      check1("rst_req_ready", bus.req_ready, 1'b0);
      check1("rst_resp_valid", bus.resp_valid, 1'b0);
      check1("rst_resp_err", bus.resp_err, 1'b0);
      check32("rst_resp_rdata", bus.resp_rdata, 32'h0);
      check1("rst_mem_ren", bus.mem_ren, 1'b0);
      check1("rst_mem_wen", bus.mem_wen, 1'b0);
      check32("rst_mem_waddr", bus.mem_waddr, 32'h0);
      check32("rst_mem_wdata", bus.mem_wdata, 32'h0);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;
      check1("rel_req_ready", bus.req_ready, 1'b1);

      // Vector table
      for (int i = 0; i < 14; i++) run_vec(vecs[i]);

      // Backpressure: response held for 5 stalled cycles, memory not re-strobed
      @(negedge clock);
      bus.mem_rdata = 32'hCAFEF00D;
      drive_req(1'b0, 32'h00000300, 32'h0, 2'd2, 1'b0);
      base = strobe_cnt;
      @(posedge clock); #1;
      bus.req_valid = 1'b0;
      @(posedge clock); #1;
      bus.mem_rdata = 32'h00000000;
      held = bus.resp_rdata;
      check32("bp_captured", held, 32'hCAFEF00D);
      for (int c = 0; c < 5; c++) begin
         check1("bp_valid", bus.resp_valid, 1'b1);
         check32("bp_rdata", bus.resp_rdata, 32'hCAFEF00D);
         check1("bp_not_ready", bus.req_ready, 1'b0);
         check1("bp_no_ren", bus.mem_ren, 1'b0);
         @(posedge clock); #1;
      end
      bus.resp_ready = 1'b1;
      @(posedge clock); #1;
      bus.resp_ready = 1'b0;
      check1("bp_done_valid", bus.resp_valid, 1'b0);
      check_int("bp_strobes", strobe_cnt - base, 1);

      // Reset asserted during ACCESS aborts the load
      @(negedge clock);
      bus.mem_rdata = 32'h55555555;
      drive_req(1'b0, 32'h00000400, 32'h0, 2'd2, 1'b0);
      @(posedge clock); #1;
      bus.req_valid = 1'b0;
      check1("ra_ren_before", bus.mem_ren, 1'b1);
      #2;
      reset = 1'b0;
      base = strobe_cnt;
      #1;
      check1("ra_ren_drop", bus.mem_ren, 1'b0);
      check1("ra_wen_drop", bus.mem_wen, 1'b0);
      check32("ra_raddr_drop", bus.mem_raddr, 32'h0);
      check1("ra_no_valid", bus.resp_valid, 1'b0);
      check1("ra_not_ready", bus.req_ready, 1'b0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;
      check1("ra_rel_ready", bus.req_ready, 1'b1);
      for (int c = 0; c < 3; c++) begin
         check1("ra_never_valid", bus.resp_valid, 1'b0);
         @(posedge clock); #1;
      end
      check_int("ra_strobes", strobe_cnt - base, 0);
      check32("ra_rdata_clear", bus.resp_rdata, 32'h0);

      // Reset asserted during RESP discards the store response
      @(negedge clock);
      drive_req(1'b1, 32'h00000500, 32'h01020304, 2'd2, 1'b0);
      @(posedge clock); #1;
      bus.req_valid = 1'b0;
      @(posedge clock); #1;
      check1("rr_valid_before", bus.resp_valid, 1'b1);
      reset = 1'b0;
      #1;
      check1("rr_valid_drop", bus.resp_valid, 1'b0);
      check1("rr_err_clear", bus.resp_err, 1'b0);
      @(negedge clock);
      reset = 1'b1;
      base = strobe_cnt;
      @(posedge clock); #1;
      check1("rr_rel_ready", bus.req_ready, 1'b1);
      check1("rr_never_valid", bus.resp_valid, 1'b0);
      @(posedge clock); #1;
      check_int("rr_strobes", strobe_cnt - base, 0);

      // Back-to-back stores with resp_ready held high
      @(negedge clock);
      bus.resp_ready = 1'b1;
      drive_req(1'b1, 32'h00000200, 32'h11223344, 2'd2, 1'b0);
      base  = strobe_cnt;
      n_acc = 0;
      for (int k = 0; k < 9; k++) begin
         #1;
         if (bus.req_valid && bus.req_ready) begin
            if (n_acc < 3) acc_k[n_acc] = k;
            n_acc++;
         end
         @(negedge clock);
      end
      bus.req_valid  = 1'b0;
      #1;
      bus.resp_ready = 1'b0;
      check_int("b2b_accepts", n_acc, 3);
      check_int("b2b_first", acc_k[0], 0);
      check_int("b2b_gap1", acc_k[1] - acc_k[0], 3);
      check_int("b2b_gap2", acc_k[2] - acc_k[1], 3);
      check_int("b2b_strobes", strobe_cnt - base, 3);

      repeat (2) @(posedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
